fxlms_weight_update: RTL and testbench

//   Downstream consumer of the secondary-path (S-hat) FIR output in the FxLMS ANC loop.

---
 rtl/fxlms_weight_update.sv | 176 +++++++++++++++++
 tb/tb_fxlms_weight_update.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fxlms_weight_update.sv
// ============================================================================
// Module      : fxlms_weight_update
// Description : FxLMS adaptive weight update. Keeps an N-deep filtered-reference
//               history and updates N weights one per cycle per error sample.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fxlms_weight_update #(
  parameter int N        = 32,
  parameter int X_W      = 32,
  parameter int E_W      = 32,
  parameter int W_W      = 32,
  parameter int R_X      = 31,
  parameter int R_E      = 31,
  parameter int R_W      = 30,
  parameter int MU_SHIFT = 8,
  parameter int ADDR_W   = $clog2(N)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              xf_valid,
  input  logic [X_W-1:0]    xf_data,
  input  logic              err_valid,
  input  logic [E_W-1:0]    err_data,
  output logic              err_ready,
  input  logic [ADDR_W-1:0] w_rd_addr,
  output logic [W_W-1:0]    w_rd_data,
  output logic              busy,
  output logic              update_done
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int P_W   = E_W + X_W;
  localparam int S_W   = W_W + 2;
  localparam int SHIFT = R_E + R_X - R_W + MU_SHIFT;

  localparam logic signed [S_W-1:0] c_S_MAX = {3'b000, {(W_W-1){1'b1}}};
  localparam logic signed [S_W-1:0] c_S_MIN = {3'b111, {(W_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]      c_LAST  = IDX_W'(N - 1);

  if (SHIFT < 0) begin : g_shift_chk
    $error("fxlms_weight_update: negative product shift");
  end
  if (P_W < S_W) begin : g_width_chk
    $error("fxlms_weight_update: product narrower than update word");
  end
  if (ADDR_W < IDX_W) begin : g_addr_chk
    $error("fxlms_weight_update: read address too narrow for N");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                     r_state, w_state_next;
  logic signed [X_W-1:0]      r_hist [N];
  logic signed [X_W-1:0]      w_hist_next [N];
  logic signed [X_W-1:0]      r_xs [N];
  logic signed [W_W-1:0]      r_w [N];
  logic signed [E_W-1:0]      r_e;
  logic [IDX_W-1:0]           r_k;
  logic                       w_accept;

  logic signed [P_W-1:0]      w_prod;
  logic signed [P_W-1:0]      w_shr;
  logic signed [S_W-1:0]      w_d;
  logic signed [W_W-1:0]      w_wk;
  logic signed [S_W-1:0]      w_s;
  logic signed [W_W-1:0]      w_sat;

  // History shift; the snapshot copies this next-state view so a sample
  // arriving with the error is included.
  always_comb begin
    w_hist_next = r_hist;
    if (xf_valid) begin
      w_hist_next[0] = xf_data;
      for (int i = 1; i < N; i++) begin
        w_hist_next[i] = r_hist[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      r_hist <= w_hist_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (err_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (r_k == c_LAST) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign err_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign update_done = (r_state == S_DONE);

  // w[k] - floor(mu*e*x'[k]) rescaled to weight format, then clamped.
  always_comb begin
    w_prod = P_W'(r_e) * P_W'(r_xs[r_k]);
    w_shr  = w_prod >>> SHIFT;
    w_d    = w_shr[S_W-1:0];
    w_wk   = r_w[r_k];
    w_s    = {{2{w_wk[W_W-1]}}, w_wk} - w_d;
    if (w_s > c_S_MAX) begin
      w_sat = {1'b0, {(W_W-1){1'b1}}};
    end else if (w_s < c_S_MIN) begin
      w_sat = {1'b1, {(W_W-1){1'b0}}};
    end else begin
      w_sat = w_s[W_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        r_xs[i] <= '0;
        r_w[i]  <= '0;
      end
      r_e <= '0;
      r_k <= '0;
    end else begin
      if (w_accept) begin
        r_e  <= err_data;
        r_xs <= w_hist_next;
        r_k  <= '0;
      end
      if (r_state == S_UPDATE) begin
        r_w[r_k] <= w_sat;
        r_k      <= r_k + 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_rd_addr == ADDR_W'(i)) begin
        w_rd_data = r_w[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fxlms_weight_update.sv
// ============================================================================
// Module      : tb_fxlms_weight_update
// Description : Directed self-checking bench for fxlms_weight_update (N=4, 16b).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fxlms_weight_update;

  logic        clock;
  logic        reset_n;
  logic        xf_valid;
  logic [15:0] xf_data;
  logic        err_valid;
  logic [15:0] err_data;
  logic        err_ready;
  logic [2:0]  w_rd_addr;
  logic [15:0] w_rd_data;
  logic        busy;
  logic        update_done;

  int r_checks;
  int r_fails;

  fxlms_weight_update #(
    .N(4), .X_W(16), .E_W(16), .W_W(16),
    .R_X(15), .R_E(15), .R_W(14), .MU_SHIFT(0), .ADDR_W(3)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .xf_valid    (xf_valid),
    .xf_data     (xf_data),
    .err_valid   (err_valid),
    .err_data    (err_data),
    .err_ready   (err_ready),
    .w_rd_addr   (w_rd_addr),
    .w_rd_data   (w_rd_data),
    .busy        (busy),
    .update_done (update_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    r_checks++;
    if (got !== exp) begin
      r_fails++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_weights(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int i = 0; i < 4; i++) begin
      w_rd_addr = 3'(i);
      #0.5;
      chk($sformatf("%s_w%0d", tag, i), {16'h0, w_rd_data}, {16'h0, exp[i]});
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic push_xf(input logic [15:0] v);
    xf_valid = 1'b1;
    xf_data  = v;
    tick();
    xf_valid = 1'b0;
  endtask

  // Accept one error, wait for the done pulse, return in the following IDLE cycle.
  task automatic run_update(input string tag, input logic [15:0] e);
    bit seen = 1'b0;
    err_valid = 1'b1;
    err_data  = e;
    tick();
    err_valid = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (update_done) seen = 1'b1;
      else tick();
    end
    chk({tag, "_done_seen"}, {31'h0, seen}, 32'h1);
    tick();
  endtask

  initial begin
    int pulses;
    r_checks  = 0;
    r_fails   = 0;
    reset_n   = 1'b0;
    xf_valid  = 1'b0;
    xf_data   = '0;
    err_valid = 1'b0;
    err_data  = '0;
    w_rd_addr = '0;

    // Reset state
    repeat (2) tick();
    chk_weights("rst", 16'h0, 16'h0, 16'h0, 16'h0);
    chk("rst_ready", {31'h0, err_ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, update_done}, 32'h0);
    reset_n = 1'b1;
    tick();

    // Basic update and timing
    push_xf(16'h4000);
    err_valid = 1'b1;
    err_data  = 16'h4000;
    tick();                                   // T+1
    err_valid = 1'b0;
    chk("t2_busy", {31'h0, busy}, 32'h1);
    chk("t2_ready", {31'h0, err_ready}, 32'h0);
    w_rd_addr = 3'd0;
    #0.5;
    chk("t2_w0_T1", {16'h0, w_rd_data}, 32'h0);
    tick();                                   // T+2
    w_rd_addr = 3'd0;
    #0.5;
    chk("t2_w0_T2", {16'h0, w_rd_data}, 32'hF000);
    tick(); tick();                           // T+4
    chk("t2_done_T4", {31'h0, update_done}, 32'h0);
    tick();                                   // T+5
    chk("t2_done_T5", {31'h0, update_done}, 32'h1);
    tick();                                   // T+6
    chk("t2_done_T6", {31'h0, update_done}, 32'h0);
    chk("t2_ready_T6", {31'h0, err_ready}, 32'h1);
    chk_weights("t2", 16'hF000, 16'h0, 16'h0, 16'h0);

    // Saturation
    do_reset();
    push_xf(16'h8000);
    run_update("t3a", 16'h8000);
    chk_weights("t3a", 16'hC000, 16'h0, 16'h0, 16'h0);
    run_update("t3b", 16'h8000);
    chk_weights("t3b", 16'h8000, 16'h0, 16'h0, 16'h0);
    run_update("t3c", 16'h8000);
    chk_weights("t3c", 16'h8000, 16'h0, 16'h0, 16'h0);

    // err_valid held through UPDATE, history pushed mid-update
    do_reset();
    push_xf(16'h4000);
    err_valid = 1'b1;
    err_data  = 16'h4000;
    tick();                                   // T+1
    xf_valid = 1'b1;
    xf_data  = 16'h2000;
    tick(); tick();                           // T+3, two pushes issued
    xf_valid = 1'b0;
    tick(); tick();                           // T+5
    chk("t4_done", {31'h0, update_done}, 32'h1);
    err_valid = 1'b0;
    tick();                                   // T+6
    chk_weights("t4a", 16'hF000, 16'h0, 16'h0, 16'h0);
    tick();
    chk("t4_no_second", {31'h0, busy}, 32'h0);
    run_update("t4b", 16'h4000);
    chk_weights("t4b", 16'hE800, 16'hF800, 16'hF000, 16'h0);

    // Reset mid-update
    do_reset();
    push_xf(16'h4000);
    err_valid = 1'b1;
    err_data  = 16'h4000;
    tick();                                   // T+1
    err_valid = 1'b0;
    tick();                                   // T+2, w0 already written
    reset_n = 1'b0;
    #0.5;
    chk_weights("t5", 16'h0, 16'h0, 16'h0, 16'h0);
    chk("t5_ready", {31'h0, err_ready}, 32'h1);
    chk("t5_busy", {31'h0, busy}, 32'h0);
    tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      if (update_done) pulses++;
      tick();
    end
    chk("t5_no_done", 32'(pulses), 32'h0);

    // Same-cycle sample and error; out-of-range reads
    xf_valid  = 1'b1;
    xf_data   = 16'h4000;
    err_valid = 1'b1;
    err_data  = 16'h4000;
    tick();
    xf_valid  = 1'b0;
    err_valid = 1'b0;
    repeat (5) tick();
    chk("t6_ready", {31'h0, err_ready}, 32'h1);
    chk_weights("t6", 16'hF000, 16'h0, 16'h0, 16'h0);
    tick();
    for (int a = 4; a < 8; a++) begin
      w_rd_addr = 3'(a);
      #0.5;
      chk($sformatf("t6_oor%0d", a), {16'h0, w_rd_data}, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_fails);
    $finish;
  end

endmodule

`default_nettype wire
